// File: rtl/mastermind_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : mastermind_pkg                                                 |
// | Purpose   : Shared types and default sizing for the guess scoring slice.   |
// |             state_t is the scorer FSM encoding; the *_D constants are the  |
// |             default parameter values used by guess_scorer and              |
// |             value_histogram.                                               |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package mastermind_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXACT   = 2'd1,
    PARTIAL = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int NUM_DIGITS_D   = 4;
  localparam int DIGIT_W_D      = 2;
  localparam int MAX_ATTEMPTS_D = 8;

endpackage : mastermind_pkg
`default_nettype wire

// File: rtl/value_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : value_histogram                                                |
// | Purpose   : One counter per possible digit value, counting how many        |
// |             unmatched digits carried that value.                           |
// | Ports     : clk, reset  - clock, synchronous active-high reset             |
// |             clr         - clear every counter                              |
// |             inc         - increment the counter selected by inc_val        |
// |             inc_val     - digit value to count                             |
// |             rd_val      - digit value to read                              |
// |             rd_cnt      - combinational count for rd_val                   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module value_histogram
  import mastermind_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_D,
  parameter int DIGIT_W    = DIGIT_W_D
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr,
  input  logic                              inc,
  input  logic [DIGIT_W-1:0]                inc_val,
  input  logic [DIGIT_W-1:0]                rd_val,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   rd_cnt
);

  localparam int c_CW   = $clog2(NUM_DIGITS + 1);
  localparam int c_NVAL = 2 ** DIGIT_W;

  logic [c_CW-1:0] r_cnt [c_NVAL];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int v = 0; v < c_NVAL; v++) begin
        r_cnt[v] <= '0;
      end
    end else if (inc) begin
      r_cnt[inc_val] <= r_cnt[inc_val] + c_CW'(1);
    end
  end

  assign rd_cnt = r_cnt[rd_val];

endmodule : value_histogram
`default_nettype wire

// File: rtl/guess_scorer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : guess_scorer                                                   |
// | Purpose   : Scores a latched guess against a latched secret code, one      |
// |             digit per cycle, returning exact and partial match counts,     |
// |             and tracks attempts plus sticky won/lost status.               |
// | Ports     : clk, reset         - clock, synchronous active-high reset      |
// |             start, new_game    - score request / game restart pulses       |
// |             code, guess        - packed digits, digit i at [i*DIGIT_W]     |
// |             busy, result_valid - scoring in progress / result pulse        |
// |             exact_cnt, partial_cnt, attempts, won, lost - score status     |
// |             dup_guess          - repeat-guess rejection pulse              |
// | Options   : REPEAT_FILTER_EN - reject a start whose guess equals the last  |
// |             scored guess; without it dup_guess is tied low.                |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module guess_scorer
  import mastermind_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_D,
  parameter int DIGIT_W      = DIGIT_W_D,
  parameter int MAX_ATTEMPTS = MAX_ATTEMPTS_D
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 new_game,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]        code,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]        guess,
  output logic                                 busy,
  output logic                                 result_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      exact_cnt,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      partial_cnt,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    attempts,
  output logic                                 won,
  output logic                                 lost,
  output logic                                 dup_guess
);

  localparam int c_W    = NUM_DIGITS * DIGIT_W;
  localparam int c_CW   = $clog2(NUM_DIGITS + 1);
  localparam int c_AW   = $clog2(MAX_ATTEMPTS + 1);
  localparam int c_NVAL = 2 ** DIGIT_W;
  // idx walks digit positions in EXACT and digit values in PARTIAL
  localparam int c_NMAX = (NUM_DIGITS > c_NVAL) ? NUM_DIGITS : c_NVAL;
  localparam int c_IW   = $clog2(c_NMAX + 1);

  state_t            r_state;
  logic [c_IW-1:0]   r_idx;
  logic [c_W-1:0]    r_code;
  logic [c_W-1:0]    r_guess;
  logic [c_CW-1:0]   r_exact;
  logic [c_CW-1:0]   r_partial;

  logic [DIGIT_W-1:0] w_code_dig;
  logic [DIGIT_W-1:0] w_guess_dig;
  logic               w_match;
  logic [c_CW-1:0]    w_hc;
  logic [c_CW-1:0]    w_hg;
  logic [c_CW-1:0]    w_min;
  logic               w_start_ok;
  logic               w_is_repeat;
  logic               w_accept;
  logic               w_hist_inc;

  // Select the current digit of the latched code and guess
  always_comb begin
    w_code_dig  = '0;
    w_guess_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_code_dig  = r_code[i*DIGIT_W +: DIGIT_W];
        w_guess_dig = r_guess[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign w_match    = (w_code_dig == w_guess_dig);
  // Only digits that missed an exact match are eligible for partial credit
  assign w_hist_inc = (r_state == EXACT) && !w_match;
  assign w_min      = (w_hc < w_hg) ? w_hc : w_hg;
  assign w_start_ok = start && !won && !lost && (r_state == IDLE);
  assign w_accept   = w_start_ok && !w_is_repeat;
  assign busy       = (r_state != IDLE);

  value_histogram #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_hist_code (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_accept),
    .inc     (w_hist_inc),
    .inc_val (w_code_dig),
    .rd_val  (r_idx[DIGIT_W-1:0]),
    .rd_cnt  (w_hc)
  );

  value_histogram #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_hist_guess (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_accept),
    .inc     (w_hist_inc),
    .inc_val (w_guess_dig),
    .rd_val  (r_idx[DIGIT_W-1:0]),
    .rd_cnt  (w_hg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_code       <= '0;
      r_guess      <= '0;
      r_exact      <= '0;
      r_partial    <= '0;
      result_valid <= 1'b0;
      exact_cnt    <= '0;
      partial_cnt  <= '0;
      attempts     <= '0;
      won          <= 1'b0;
      lost         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (new_game) begin
        r_state     <= IDLE;
        attempts    <= '0;
        won         <= 1'b0;
        lost        <= 1'b0;
        exact_cnt   <= '0;
        partial_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_code    <= code;
              r_guess   <= guess;
              r_exact   <= '0;
              r_partial <= '0;
              r_idx     <= '0;
              r_state   <= EXACT;
            end
          end
          EXACT: begin
            if (w_match) begin
              r_exact <= r_exact + c_CW'(1);
            end
            if (r_idx == c_IW'(NUM_DIGITS - 1)) begin
              r_idx   <= '0;
              r_state <= PARTIAL;
            end else begin
              r_idx <= r_idx + c_IW'(1);
            end
          end
          PARTIAL: begin
            r_partial <= r_partial + w_min;
            if (r_idx == c_IW'(c_NVAL - 1)) begin
              r_idx   <= '0;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + c_IW'(1);
            end
          end
          DONE: begin
            exact_cnt    <= r_exact;
            partial_cnt  <= r_partial;
            result_valid <= 1'b1;
            if (attempts != c_AW'(MAX_ATTEMPTS)) begin
              attempts <= attempts + c_AW'(1);
            end
            if (r_exact == c_CW'(NUM_DIGITS)) begin
              won <= 1'b1;
            end else if (attempts == c_AW'(MAX_ATTEMPTS - 1)) begin
              lost <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef REPEAT_FILTER_EN
  logic [c_W-1:0] r_last_guess;
  logic           r_last_valid;

  assign w_is_repeat = r_last_valid && (guess == r_last_guess);

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      r_last_guess <= '0;
      r_last_valid <= 1'b0;
      dup_guess    <= 1'b0;
    end else begin
      dup_guess <= w_start_ok && w_is_repeat;
      if (r_state == DONE) begin
        r_last_guess <= r_guess;
        r_last_valid <= 1'b1;
      end
    end
  end
`else
  assign w_is_repeat = 1'b0;
  assign dup_guess   = 1'b0;
`endif

endmodule : guess_scorer
`default_nettype wire

// File: doc/guess_scorer.md
Name: guess_scorer

Overview:
- Scores a latched player guess against the latched secret code, one digit per cycle, and returns exact (right value, right position) and partial (right value, wrong position) counts.
- Tracks the attempt count and the sticky won/lost game status.
- Sits downstream of the guess register and the LFSR code generator.
- Feeds the HEX score display and LED status logic.

Parameters:
- NUM_DIGITS, 4, number of code digits.
- DIGIT_W, 2, bits per digit; digit values range over 0..2**DIGIT_W-1.
- MAX_ATTEMPTS, 8, number of scored non-winning guesses allowed before the game is lost.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle score request; ignored unless state is IDLE and the game is not won/lost.
- new_game  input  1  one-cycle pulse; clears attempts/won/lost and aborts any scoring in progress.
- code  input  NUM_DIGITS*DIGIT_W  secret code; digit i = code[i*DIGIT_W +: DIGIT_W].
- guess  input  NUM_DIGITS*DIGIT_W  player guess; same digit packing as code.
- busy  output  1  high whenever state is not IDLE.
- result_valid  output  1  one-cycle pulse when exact_cnt/partial_cnt are updated.
- exact_cnt  output  $clog2(NUM_DIGITS+1)  exact-match count of the last scored guess.
- partial_cnt  output  $clog2(NUM_DIGITS+1)  value-only match count of the last scored guess.
- attempts  output  $clog2(MAX_ATTEMPTS+1)  number of guesses scored in this game.
- won  output  1  sticky; set when exact_cnt == NUM_DIGITS.
- lost  output  1  sticky; set when attempts reaches MAX_ATTEMPTS without a win.
- dup_guess  output  1  one-cycle pulse marking a rejected repeat guess; tied 0 unless REPEAT_FILTER_EN.

Behaviour:
- Reset values:
  - state IDLE.
  - busy, result_valid, won, lost, dup_guess = 0.
  - exact_cnt, partial_cnt, attempts = 0.
  - histograms cleared.
- Priority: reset > new_game > start.
- FSM states: IDLE, EXACT, PARTIAL, DONE.
- IDLE:
  - On start && !won && !lost at edge E0: latch code and guess, clear the running counts and both histograms, go to EXACT with idx=0.
- EXACT: runs NUM_DIGITS cycles, idx = 0..NUM_DIGITS-1.
  - Digit match: increment the running exact count.
  - Otherwise: increment hist_code[code_idx] and hist_guess[guess_idx].
  - After the last idx: go to PARTIAL.
- PARTIAL: runs 2**DIGIT_W cycles, v = 0..2**DIGIT_W-1.
  - Each cycle: running partial += min(hist_code[v], hist_guess[v]).
  - After the last v: go to DONE.
- DONE: one cycle, then back to IDLE. In this cycle:
  - Register exact_cnt and partial_cnt, pulse result_valid, increment attempts.
  - If exact == NUM_DIGITS: set won.
  - Else if the incremented attempts == MAX_ATTEMPTS: set lost.
- Latency with defaults: result_valid is high in the cycle after edge E9, i.e. 1 + NUM_DIGITS + 2**DIGIT_W edges after E0.
- Outputs exact_cnt, partial_cnt, won, lost, attempts hold their values between results.
- start while busy, won, or lost: ignored, with no side effects.
- new_game in any state:
  - Go to IDLE; clear attempts, won, lost, exact_cnt, partial_cnt.
  - No result_valid is issued.
  - A start in the same cycle is dropped.
- code/guess changing during scoring: no effect, because both are latched at E0.
- attempts saturates at MAX_ATTEMPTS; it cannot wrap because lost blocks further starts.
- reset mid-scoring: all state returns to reset values at that edge.

Optional Feature:
- Macro: REPEAT_FILTER_EN.
- With the macro defined:
  - Keep last_guess (cleared by reset/new_game) and a valid bit.
  - A start whose guess equals last_guess while valid is set is rejected: state stays IDLE, attempts is unchanged, and dup_guess pulses one cycle.
  - last_guess is updated in DONE.
- Without the macro: no last_guess storage, dup_guess is constant 0, and every qualifying start is scored.

Decomposition:
- Package mastermind_pkg holds:
  - Enum state_t {IDLE, EXACT, PARTIAL, DONE}.
  - Default constants NUM_DIGITS_D=4, DIGIT_W_D=2, MAX_ATTEMPTS_D=8.
- Sub-module value_histogram:
  - Bank of 2**DIGIT_W counters, each $clog2(NUM_DIGITS+1) wide.
  - Ports: clr, inc, inc_val, rd_val, rd_cnt.
  - Instantiated twice, once for code and once for guess.

Test Plan:
- Full match: code=8'h1B, guess=8'h1B, start -> result_valid exactly 9 edges after start; exact_cnt=4, partial_cnt=0, attempts=1, won=1; a further start is ignored.
- All misplaced: code=8'h1B (digits 3,2,1,0 = 0,1,2,3), guess=8'hE4 -> exact_cnt=0, partial_cnt=4, won=0.
- Repeated values: code digits {0,0,1,1}, guess digits {1,1,0,2} -> exact_cnt=0, partial_cnt=3 (value 0 contributes 1, value 1 contributes 2).
- Exhaustion: 8 non-winning guesses -> attempts=8, lost=1 on the 8th result_valid; a 9th start is ignored (busy stays 0).
- Abort: new_game asserted while in PARTIAL -> busy=0 the next cycle, no result_valid, attempts=0; reset during EXACT gives all outputs 0.
- REPEAT_FILTER_EN: score guess 8'h55, then start with 8'h55 again -> dup_guess pulses, attempts stays 1, no result_valid.
